// File: rtl/cpu7_ibuf.sv
// Instruction buffer between fetch and the EXU port0 issue interface.
// DEPTH-entry FIFO with valid/ready on both sides and a hold-off after an excepting fetch.
module cpu7_ibuf #(
  parameter int unsigned GRLEN = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [GRLEN-1:0] fetch_pc,
  input  logic [31:0]      fetch_inst,
  input  logic             fetch_exception,
  input  logic [5:0]       fetch_exccode,
  input  logic             flush,
  output logic             port0_valid,
  input  logic             port0_ready,
  output logic [GRLEN-1:0] port0_pc,
  output logic [31:0]      port0_inst,
  output logic             port0_exception,
  output logic [5:0]       port0_exccode,
  output logic [PTR_W:0]   ibuf_count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_NORMAL   = 1'b0,
    ST_EXC_HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [GRLEN-1:0] r_pc_mem   [DEPTH];
  logic [31:0]      r_inst_mem [DEPTH];
  logic             r_exc_mem  [DEPTH];
  logic [5:0]       r_code_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready depends only on registered state and flush, never on port0_ready.
  assign fetch_ready = resetn & ~w_full & (r_state == ST_NORMAL) & ~flush;
  assign port0_valid = ~w_empty;

  assign w_enq = fetch_valid & fetch_ready;
  assign w_deq = port0_valid & port0_ready;

  assign port0_pc        = w_empty ? '0   : r_pc_mem[r_rd_ptr];
  assign port0_inst      = w_empty ? '0   : r_inst_mem[r_rd_ptr];
  assign port0_exception = w_empty ? 1'b0 : r_exc_mem[r_rd_ptr];
  assign port0_exccode   = w_empty ? '0   : r_code_mem[r_rd_ptr];
  assign ibuf_count      = r_count;

  // Pointers, occupancy and exception hold state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_NORMAL;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_state  <= ST_NORMAL;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      case (r_state)
        ST_NORMAL: begin
          if (w_enq && fetch_exception) begin
            r_state <= ST_EXC_HOLD;
          end
        end
        ST_EXC_HOLD: begin
          if (w_deq && port0_exception) begin
            r_state <= ST_NORMAL;
          end
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  // Payload storage needs no reset: it is masked while empty.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_pc_mem[r_wr_ptr]   <= fetch_pc;
      r_inst_mem[r_wr_ptr] <= fetch_inst;
      r_exc_mem[r_wr_ptr]  <= fetch_exception;
      r_code_mem[r_wr_ptr] <= fetch_exccode;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      assert (!(w_enq && !w_deq && w_full));
      assert (!(w_deq && w_empty));
    end
  end

endmodule

// File: tb/tb_cpu7_ibuf.sv
// Scoreboard bench for cpu7_ibuf: a queue-based reference model is checked mid-cycle
// against every output; directed scenarios are followed by randomized traffic.
module tb_cpu7_ibuf;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  code;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_pc = '0;
  logic [31:0] fetch_inst = '0;
  logic        fetch_exception = 1'b0;
  logic [5:0]  fetch_exccode = '0;
  logic        flush = 1'b0;
  logic        port0_valid;
  logic        port0_ready = 1'b0;
  logic [31:0] port0_pc;
  logic [31:0] port0_inst;
  logic        port0_exception;
  logic [5:0]  port0_exccode;
  logic [2:0]  ibuf_count;

  int n_tests = 0;
  int n_fail  = 0;
  ent_t sb_q[$];

  cpu7_ibuf #(.GRLEN(32), .DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
    .fetch_exception(fetch_exception), .fetch_exccode(fetch_exccode),
    .flush(flush),
    .port0_valid(port0_valid), .port0_ready(port0_ready),
    .port0_pc(port0_pc), .port0_inst(port0_inst),
    .port0_exception(port0_exception), .port0_exccode(port0_exccode),
    .ibuf_count(ibuf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit q_has_exc();
    foreach (sb_q[i]) if (sb_q[i].exc) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: mid-cycle compare of every output, then advance the reference queue.
  always @(negedge clk) begin
    ent_t head;
    ent_t got;
    bit   exp_ready;
    bit   enq;
    bit   deq;
    if (!resetn) begin
      sb_q.delete();
      chk("rst_ready", 128'(fetch_ready), 128'(0));
      chk("rst_valid", 128'(port0_valid), 128'(0));
      chk("rst_count", 128'(ibuf_count), 128'(0));
      chk("rst_pc", 128'(port0_pc), 128'(0));
    end else begin
      exp_ready = !flush && (sb_q.size() < 4) && !q_has_exc();
      head = (sb_q.size() != 0) ? sb_q[0] : '0;
      got  = '{pc: port0_pc, inst: port0_inst, exc: port0_exception, code: port0_exccode};
      chk("fetch_ready", 128'(fetch_ready), 128'(exp_ready));
      chk("port0_valid", 128'(port0_valid), 128'(sb_q.size() != 0));
      chk("ibuf_count", 128'(ibuf_count), 128'(sb_q.size()));
      chk("payload", 128'(got), 128'(head));
      enq = fetch_valid && exp_ready;
      deq = (sb_q.size() != 0) && port0_ready;
      if (flush) begin
        sb_q.delete();
      end else begin
        if (deq) void'(sb_q.pop_front());
        if (enq) sb_q.push_back('{pc: fetch_pc, inst: fetch_inst,
                                   exc: fetch_exception, code: fetch_exccode});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry, holding it until accepted or max_cyc cycles pass.
  task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic exc,
                      input logic [5:0] code, input int max_cyc, output bit acc);
    acc = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc = pc;
    fetch_inst = inst;
    fetch_exception = exc;
    fetch_exccode = code;
    for (int i = 0; i < max_cyc && !acc; i++) begin
      @(negedge clk);
      acc = fetch_ready;
      cycle();
    end
    fetch_valid = 1'b0;
    fetch_exception = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit acc;
    resetn = 1'b0;
    idle(3);
    resetn = 1'b1;
    idle(1);

    // Single entry through an always-ready EXU.
    port0_ready = 1'b1;
    send(32'h1c000000, 32'h02800421, 1'b0, 6'h0, 4, acc);
    chk("t1_accept", 128'(acc), 128'(1));
    idle(3);

    // Fill with backpressure, fifth entry must be blocked.
    port0_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(32'h100 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 6'h0, 4, acc);
      chk("fill_accept", 128'(acc), 128'(1));
    end
    send(32'h110, 32'hA004, 1'b0, 6'h0, 3, acc);
    chk("full_block", 128'(acc), 128'(0));
    chk("full_head", 128'(port0_pc), 128'(32'h100));
    port0_ready = 1'b1;
    send(32'h110, 32'hA004, 1'b0, 6'h0, 10, acc);
    chk("full_release", 128'(acc), 128'(1));
    idle(8);

    // Continuous stream wraps the pointers.
    for (int i = 0; i < 12; i++) begin
      send(32'h1000 + 32'(4 * i), $urandom, 1'b0, 6'h0, 4, acc);
      chk("stream_accept", 128'(acc), 128'(1));
    end
    idle(3);

    // Exception hold: nothing accepted until the excepting entry drains.
    port0_ready = 1'b0;
    send(32'h200, 32'hB000, 1'b0, 6'h0, 4, acc);
    chk("exc_first", 128'(acc), 128'(1));
    send(32'h204, 32'hB004, 1'b1, 6'h08, 4, acc);
    chk("exc_entry", 128'(acc), 128'(1));
    send(32'h208, 32'hB008, 1'b0, 6'h0, 3, acc);
    chk("exc_block", 128'(acc), 128'(0));
    port0_ready = 1'b1;
    send(32'h208, 32'hB008, 1'b0, 6'h0, 10, acc);
    chk("exc_release", 128'(acc), 128'(1));
    idle(3);

    // Flush with a competing fetch and consume.
    port0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(32'h300 + 32'(4 * i), 32'hC000 + 32'(i), 1'b0, 6'h0, 4, acc);
    end
    fetch_valid = 1'b1;
    fetch_pc = 32'h3ff;
    port0_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    fetch_valid = 1'b0;
    #1;
    chk("flush_valid", 128'(port0_valid), 128'(0));
    chk("flush_count", 128'(ibuf_count), 128'(0));
    send(32'h400, 32'hD000, 1'b0, 6'h0, 4, acc);
    chk("flush_after", 128'(acc), 128'(1));
    idle(3);

    // Async reset between edges with two entries buffered.
    port0_ready = 1'b0;
    send(32'h500, 32'hE000, 1'b0, 6'h0, 4, acc);
    send(32'h504, 32'hE004, 1'b0, 6'h0, 4, acc);
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 128'(port0_valid), 128'(0));
    chk("arst_count", 128'(ibuf_count), 128'(0));
    cycle();
    resetn = 1'b1;
    idle(1);

    // Randomized traffic including exceptions and flushes.
    for (int i = 0; i < 400; i++) begin
      fetch_valid     = ($urandom_range(0, 3) != 0);
      fetch_pc        = $urandom;
      fetch_inst      = $urandom;
      fetch_exception = ($urandom_range(0, 7) == 0);
      fetch_exccode   = 6'($urandom);
      port0_ready     = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 24) == 0);
      cycle();
    end
    fetch_valid = 1'b0;
    flush = 1'b0;
    port0_ready = 1'b1;
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu7_ibuf.md
Name: cpu7_ibuf

Overview:
- Instruction buffer between fetch and the execute unit's port0 issue interface.
- Accepts fetched pc/inst/exception tuples via a valid/ready handshake and stores them in a DEPTH-entry FIFO.
- Drives port0_valid/pc/inst/exception/exccode toward the EXU, with backpressure from port0_ready.
- Holds off further fetch after an excepting instruction until that instruction drains or a flush occurs.

Parameters:
- GRLEN, 32, address/pc width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- fetch_valid  in  1  fetch offers an entry.
- fetch_ready  out  1  buffer accepts the entry this cycle.
- fetch_pc  in  GRLEN  pc of the offered instruction.
- fetch_inst  in  32  instruction word.
- fetch_exception  in  1  fetch-side exception (e.g. ADEF, TLB) on this entry.
- fetch_exccode  in  6  exception code; meaningful only when fetch_exception=1.
- flush  in  1  pipeline flush (branch mispredict or exception commit).
- port0_valid  out  1  head entry presented to the EXU.
- port0_ready  in  1  EXU consumes the head entry this cycle.
- port0_pc  out  GRLEN  head pc.
- port0_inst  out  32  head instruction.
- port0_exception  out  1  head exception flag.
- port0_exccode  out  6  head exception code.
- ibuf_count  out  PTR_W+1  number of occupied entries.

Behaviour:
- Reset, asynchronous on resetn=0:
  - rd_ptr=wr_ptr=0, count=0, state=NORMAL.
  - Outputs: port0_valid=0, all port0 payload=0, ibuf_count=0, fetch_ready=0 while resetn=0.
- Enqueue: enq = fetch_valid & fetch_ready. Writes the entry at wr_ptr; wr_ptr+1 mod DEPTH.
- Dequeue: deq = port0_valid & port0_ready. rd_ptr+1 mod DEPTH.
- Count update: count' = count + enq - deq. Simultaneous enq and deq leaves count unchanged.
- fetch_ready = resetn & (count != DEPTH) & (state == NORMAL) & !flush.
  - It is a function of registered state plus flush only; it never depends on port0_ready. No same-cycle slot reuse when full.
- port0_valid = (count != 0). Payload is the entry at rd_ptr, or forced to 0 when count == 0.
- Latency: an entry enqueued at edge N is visible on port0 in the cycle after edge N. There is no combinational fetch-to-port0 bypass.
- Payload stability: while port0_valid=1 and port0_ready=0, the payload holds constant.
- Pointer wrap: the pointers wrap modulo DEPTH. Full vs. empty is distinguished only by count.
- State machine:
  - NORMAL -> EXC_HOLD when enq occurs with fetch_exception=1.
  - EXC_HOLD -> NORMAL when deq occurs on the head entry with port0_exception=1, or on flush.
  - In EXC_HOLD, fetch_ready=0. Entries already buffered before the exception entry still drain normally.
- Flush:
  - On a cycle with flush=1, the next edge sets count=0, rd_ptr=wr_ptr=0, state=NORMAL.
  - Any enq that cycle is suppressed (fetch_ready is already 0). A deq that cycle is ignored.
  - port0_valid=0 in the cycle after the flush edge.
- Arithmetic: count is PTR_W+1 bits and saturates by construction (no enq when full, no deq when empty). Overflow and underflow are illegal and asserted in simulation.
- Exccode is stored verbatim and not decoded.

Test Plan:
- Reset, then 1 entry:
  - Stimulus: resetn low then high; fetch_valid=1 with pc=0x1c000000, inst=0x02800421 for one cycle; port0_ready=1.
  - Response: port0_valid=1 exactly one cycle later with that pc/inst; ibuf_count goes 1 then 0; port0_pc=0 when idle.
- Fill and backpressure:
  - Stimulus: port0_ready=0; 5 back-to-back fetches pc=0x100,0x104,0x108,0x10c,0x110.
  - Response: first 4 accepted, fetch_ready=0 at count=4, 0x110 held by fetch; port0_pc stays 0x100.
  - Then port0_ready=1: output order 0x100..0x110, no loss or duplication.
- Simultaneous enq/deq with wrap:
  - Stimulus: stream 12 entries with port0_ready=1 continuously.
  - Response: ibuf_count stays 1 after warmup; pointers wrap 3 times; in-order output.
- Exception hold:
  - Stimulus: enqueue pc=0x200 normal, then pc=0x204 with exception=1, exccode=0x08, then offer pc=0x208.
  - Response: fetch_ready=0 after 0x204 is accepted.
  - After 0x204 is dequeued with port0_exception=1 and port0_exccode=0x08, fetch_ready returns to 1 and 0x208 is accepted.
- Flush mid-stream:
  - Stimulus: 3 entries buffered; assert flush with fetch_valid=1 and port0_ready=1 in the same cycle.
  - Response: the offered entry is not accepted; next cycle port0_valid=0, ibuf_count=0, state NORMAL; subsequent fetch is accepted normally.
- Async reset mid-operation:
  - Stimulus: drop resetn between edges with 2 entries buffered.
  - Response: port0_valid and ibuf_count go to 0 immediately, without waiting for a clock edge.
